logic_analyzer_capture_fsm: RTL and testbench

//  Capture sequencer for the logic analyzer core; consumes trigger_mode/trigger_loc/request_start/request_stop

---
 rtl/logic_analyzer_pkg.sv | 16 +
 rtl/logic_analyzer_capture_fsm.sv | 148 ++++++++++++++
 tb/tb_logic_analyzer_capture_fsm.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/logic_analyzer_pkg.sv
// Shared state encoding and trigger-mode constants for the logic analyzer capture path.
package logic_analyzer_pkg;

    typedef enum logic [3:0] {
        IDLE             = 4'd0,
        MOVE_TO_POSITION = 4'd1,
        IN_POSITION      = 4'd2,
        CAPTURING        = 4'd3,
        CAPTURED         = 4'd4
    } la_state_e;

    localparam logic [1:0] MODE_SINGLE_SHOT = 2'd0;
    localparam logic [1:0] MODE_INCREMENTAL = 2'd1;
    localparam logic [1:0] MODE_IMMEDIATE   = 2'd2;

endpackage

// File: rtl/logic_analyzer_capture_fsm.sv
// Capture sequencer: circular sample buffer with pre-trigger window and registered BRAM write port.
// Optional LA_TRIGGER_TIMESTAMP_EN adds a free-running cycle counter and trigger_time output.
//
// state            | meaning
// IDLE             | no writes, waiting for start edge
// MOVE_TO_POSITION | filling the first loc_eff pre-trigger samples
// IN_POSITION      | pre-trigger window full, rolling, waiting for trig_i
// CAPTURING        | post-trigger writes until the buffer is full
// CAPTURED         | buffer full, frozen until stop edge
module logic_analyzer_capture_fsm
    import logic_analyzer_pkg::*;
#(
    parameter int SAMPLE_DEPTH = 1024,
    parameter int ADDR_WIDTH   = $clog2(SAMPLE_DEPTH),
    parameter int PROBE_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             trigger_mode,
    input  logic [15:0]            trigger_loc,
    input  logic                   request_start,
    input  logic                   request_stop,
    input  logic                   trig_i,
    input  logic [PROBE_WIDTH-1:0] probes_i,
    output logic [3:0]             state,
    output logic [ADDR_WIDTH-1:0]  read_pointer,
    output logic [ADDR_WIDTH-1:0]  write_pointer,
    output logic                   bram_we_o,
    output logic [ADDR_WIDTH-1:0]  bram_addr_o,
    output logic [PROBE_WIDTH-1:0] bram_wdata_o
`ifdef LA_TRIGGER_TIMESTAMP_EN
    ,
    output logic [31:0]            trigger_time
`endif
);

    la_state_e             state_r;
    logic                  start_q;
    logic                  stop_q;
    logic                  start_edge;
    logic                  stop_edge;
    logic [1:0]            mode_l;
    logic [1:0]            mode_in;
    logic [ADDR_WIDTH-1:0] loc_eff;
    logic [ADDR_WIDTH-1:0] loc_in;
    logic [ADDR_WIDTH-1:0] wp_inc;
    logic                  accept;

    assign start_edge = request_start & ~start_q;
    assign stop_edge  = request_stop & ~stop_q;
    assign wp_inc     = write_pointer + 1'b1;
    assign state      = state_r;

    assign loc_in  = (32'(trigger_loc) >= 32'(SAMPLE_DEPTH - 1)) ? ADDR_WIDTH'(SAMPLE_DEPTH - 1)
                                                                 : ADDR_WIDTH'(trigger_loc);
    assign mode_in = (trigger_mode == MODE_INCREMENTAL || trigger_mode == MODE_IMMEDIATE)
                   ? trigger_mode : MODE_SINGLE_SHOT;

    // A stop edge suppresses the sample of that cycle so the frozen pointers match memory contents.
    always_comb begin
        accept = 1'b0;
        if (!stop_edge) begin
            case (state_r)
                MOVE_TO_POSITION: accept = 1'b1;
                IN_POSITION:      accept = 1'b1;
                CAPTURING:        accept = (mode_l == MODE_INCREMENTAL) ? trig_i : 1'b1;
                default:          accept = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            start_q       <= 1'b0;
            stop_q        <= 1'b0;
            mode_l        <= MODE_SINGLE_SHOT;
            loc_eff       <= '0;
            read_pointer  <= '0;
            write_pointer <= '0;
            bram_we_o     <= 1'b0;
            bram_addr_o   <= '0;
            bram_wdata_o  <= '0;
        end else begin
            start_q   <= request_start;
            stop_q    <= request_stop;
            bram_we_o <= accept;
            if (accept) begin
                bram_addr_o   <= write_pointer;
                bram_wdata_o  <= probes_i;
                write_pointer <= wp_inc;
            end

            if (stop_edge) begin
                state_r <= IDLE;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start_edge) begin
                            write_pointer <= '0;
                            read_pointer  <= '0;
                            loc_eff       <= loc_in;
                            mode_l        <= mode_in;
                            if (mode_in == MODE_SINGLE_SHOT)
                                state_r <= (loc_in == '0) ? IN_POSITION : MOVE_TO_POSITION;
                            else
                                state_r <= CAPTURING;
                        end
                    end
                    MOVE_TO_POSITION: begin
                        if (wp_inc == loc_eff)
                            state_r <= IN_POSITION;
                    end
                    IN_POSITION: begin
                        // With loc_eff = depth-1 the trigger sample itself completes the buffer.
                        if (trig_i)
                            state_r <= (wp_inc == read_pointer) ? CAPTURED : CAPTURING;
                        else
                            read_pointer <= wp_inc - loc_eff;
                    end
                    CAPTURING: begin
                        if (accept && wp_inc == read_pointer)
                            state_r <= CAPTURED;
                    end
                    default: state_r <= state_r;
                endcase
            end
        end
    end

`ifdef LA_TRIGGER_TIMESTAMP_EN
    logic [31:0] cycle_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count  <= '0;
            trigger_time <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (!stop_edge && state_r == IDLE && start_edge)
                trigger_time <= (mode_in == MODE_SINGLE_SHOT) ? 32'd0 : cycle_count;
            else if (!stop_edge && state_r == IN_POSITION && trig_i)
                trigger_time <= cycle_count;
        end
    end
`endif

endmodule

// File: tb/tb_logic_analyzer_capture_fsm.sv
// Directed bench for logic_analyzer_capture_fsm (depth 16) with a write-port scoreboard.
module tb_logic_analyzer_capture_fsm;
    import logic_analyzer_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int PW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    trigger_mode = '0;
    logic [15:0]   trigger_loc = '0;
    logic          request_start = 1'b0;
    logic          request_stop = 1'b0;
    logic          trig_i = 1'b0;
    logic [PW-1:0] probes_i = '0;
    logic [3:0]    state;
    logic [AW-1:0] read_pointer;
    logic [AW-1:0] write_pointer;
    logic          bram_we_o;
    logic [AW-1:0] bram_addr_o;
    logic [PW-1:0] bram_wdata_o;
`ifdef LA_TRIGGER_TIMESTAMP_EN
    logic [31:0]   trigger_time;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [PW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    logic [AW-1:0] exp_wp = '0;
    logic [PW-1:0] mem [DEPTH];
    int            n_pass = 0;
    int            n_total = 0;

    logic_analyzer_capture_fsm #(.SAMPLE_DEPTH(DEPTH), .ADDR_WIDTH(AW), .PROBE_WIDTH(PW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .trigger_mode  (trigger_mode),
        .trigger_loc   (trigger_loc),
        .request_start (request_start),
        .request_stop  (request_stop),
        .trig_i        (trig_i),
        .probes_i      (probes_i),
        .state         (state),
        .read_pointer  (read_pointer),
        .write_pointer (write_pointer),
        .bram_we_o     (bram_we_o),
        .bram_addr_o   (bram_addr_o),
        .bram_wdata_o  (bram_wdata_o)
`ifdef LA_TRIGGER_TIMESTAMP_EN
        ,
        .trigger_time  (trigger_time)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor: every write the DUT presents must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && bram_we_o) begin
            mem[bram_addr_o] = bram_wdata_o;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: actual addr=%0d data=%0h required no write at %0t",
                         bram_addr_o, bram_wdata_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("bram_write", 32'({bram_addr_o, bram_wdata_o}), 32'(mon_e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic t, input logic [PW-1:0] p, input logic acc);
        trig_i   = t;
        probes_i = p;
        if (acc) begin
            exp_q.push_back({exp_wp, p});
            exp_wp++;
        end
        step();
    endtask

    task automatic arm(input logic [1:0] m, input logic [15:0] loc);
        trigger_mode  = m;
        trigger_loc   = loc;
        request_start = 1'b1;
        trig_i        = 1'b0;
        exp_wp        = '0;
        step();
    endtask

    task automatic disarm();
        request_stop  = 1'b1;
        request_start = 1'b0;
        trig_i        = 1'b0;
        step();
        check("stop_to_idle", 32'(state), 32'(IDLE));
        request_stop = 1'b0;
        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_state", 32'(state), 32'(IDLE));
        check("reset_rp", 32'(read_pointer), 32'd0);
        check("reset_wp", 32'(write_pointer), 32'd0);
        check("reset_we", 32'(bram_we_o), 32'd0);
        check("reset_addr_data", 32'({bram_addr_o, bram_wdata_o}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // Async reset in the middle of an immediate capture
        arm(MODE_IMMEDIATE, 16'd0);
        check("t1_capturing", 32'(state), 32'(CAPTURING));
        for (int i = 0; i < 3; i++) cyc(1'b0, PW'(8'hA0 + i), 1'b1);
        probes_i = 8'hFF;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t1_reset_state", 32'(state), 32'(IDLE));
        check("t1_reset_ptrs", 32'({read_pointer, write_pointer}), 32'd0);
        check("t1_reset_we", 32'(bram_we_o), 32'd0);
        check("t1_queue_drained", 32'(exp_q.size()), 32'd0);
        request_start = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // Immediate mode: capturing right after start, full after 16 writes
        arm(MODE_IMMEDIATE, 16'd3);
        check("t3_capturing", 32'(state), 32'(CAPTURING));
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, PW'(8'h30 + i), 1'b1);
            if (i == 14) check("t3_still_capturing", 32'(state), 32'(CAPTURING));
        end
        check("t3_captured", 32'(state), 32'(CAPTURED));
        check("t3_rp", 32'(read_pointer), 32'd0);
        check("t3_wp", 32'(write_pointer), 32'd0);
        request_start = 1'b0;
        cyc(1'b1, 8'h11, 1'b0);
        request_start = 1'b1;
        cyc(1'b1, 8'h12, 1'b0);
        check("t3_start_ignored", 32'(state), 32'(CAPTURED));
        disarm();

        // Incremental mode: writes only on trigger pulses
        arm(MODE_INCREMENTAL, 16'd0);
        check("t4_capturing", 32'(state), 32'(CAPTURING));
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, PW'(8'h50 + i), 1'b1);
            if (i == 14) check("t4_still_capturing", 32'(state), 32'(CAPTURING));
            if (i == 15) check("t4_captured", 32'(state), 32'(CAPTURED));
            for (int g = 0; g < (i % 3) + 1; g++) cyc(1'b0, 8'hEE, 1'b0);
        end
        disarm();

        // Single-shot, loc 4, trigger in the 10th cycle after the start edge
        arm(MODE_SINGLE_SHOT, 16'd4);
        check("t2_move", 32'(state), 32'(MOVE_TO_POSITION));
        for (int c = 1; c <= 4; c++) cyc(1'b0, PW'(8'h20 + c), 1'b1);
        check("t2_in_position", 32'(state), 32'(IN_POSITION));
        for (int c = 5; c <= 9; c++) cyc(1'b0, PW'(8'h20 + c), 1'b1);
        cyc(1'b1, 8'h2A, 1'b1);
        check("t2_capturing", 32'(state), 32'(CAPTURING));
        check("t2_rp_trigger", 32'(read_pointer), 32'd5);
        for (int c = 11; c <= 21; c++) begin
            cyc(1'b0, PW'(8'h20 + c), 1'b1);
            if (c == 20) check("t2_still_capturing", 32'(state), 32'(CAPTURING));
        end
        check("t2_captured", 32'(state), 32'(CAPTURED));
        check("t2_rp_final", 32'(read_pointer), 32'd5);
        check("t2_wp_final", 32'(write_pointer), 32'd5);
        cyc(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) check("t2_pre_sample", 32'(mem[5 + k]), 32'(8'h26 + k));
        check("t2_trigger_sample", 32'(mem[9]), 32'h2A);
        disarm();

        // loc 100 clamps to 15; simultaneous start and stop stays idle
        arm(MODE_SINGLE_SHOT, 16'd100);
        for (int c = 1; c <= 15; c++) begin
            cyc(1'b0, PW'(8'h70 + c), 1'b1);
            if (c == 14) check("t5_still_moving", 32'(state), 32'(MOVE_TO_POSITION));
        end
        check("t5_in_position", 32'(state), 32'(IN_POSITION));
        disarm();
        request_start = 1'b1;
        request_stop  = 1'b1;
        step();
        check("t5_start_stop_idle", 32'(state), 32'(IDLE));
        check("t5_wp_unchanged", 32'(write_pointer), 32'd15);
        request_start = 1'b0;
        request_stop  = 1'b0;
        step();

        // Stop during IN_POSITION freezes pointers; held start level does not rearm
        arm(MODE_SINGLE_SHOT, 16'd2);
        for (int c = 1; c <= 5; c++) cyc(1'b0, PW'(8'h90 + c), 1'b1);
        check("t6_in_position", 32'(state), 32'(IN_POSITION));
        request_stop = 1'b1;
        cyc(1'b0, 8'hBB, 1'b0);
        check("t6_idle", 32'(state), 32'(IDLE));
        check("t6_ptrs_frozen", 32'({read_pointer, write_pointer}), 32'({4'd3, 4'd5}));
        request_stop = 1'b0;
        for (int c = 0; c < 4; c++) cyc(1'b1, 8'hCC, 1'b0);
        check("t6_no_rearm", 32'(state), 32'(IDLE));
        check("t6_wp_held", 32'(write_pointer), 32'd5);
        request_start = 1'b0;
        step();
        check("t6_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
